// File: rtl/wb_cmd_responder.sv
// -----------------------------------------------------------------------------
// wb_cmd_responder
//
// Wishbone slave front end of the I2C byte-level master. Decodes the four
// byte-wide registers (CSR, DPR, CMDR, FSMR), launches byte-level commands to
// the downstream I2C engine over a valid/ready handshake, captures the engine's
// completion status into CMDR and raises a level interrupt when enabled.
//
// Register map (wb_adr_i):
//   00 CSR  : [7] E, [6] IE (RW); [5] BB, [4] BC (RO); [3:0] selected bus ID (RO)
//   01 DPR  : data byte for WRITE / bus ID for SET_BUS / result of READ_*
//   10 CMDR : [7] DON, [6] NAK, [5] AL, [4] ERR (RO); [3] 0; [2:0] last command
//   11 FSMR : debug view, reads 0 unless WB_CMD_RESPONDER_FSMR_EN is defined
//
// Optional feature macro: WB_CMD_RESPONDER_FSMR_EN
//   defined   : FSMR = {state[1:0], cmd_valid_o, rsp_pending, last_cmd[2:0], 0}
//   undefined : FSMR = 8'h00
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i      Wishbone cycle, strobe, write enable
//   wb_adr_i[1:0]            register select
//   wb_dat_i[7:0]            write data
//   wb_dat_o[7:0]            read data, valid on the ack cycle
//   wb_ack_o                 registered single-cycle acknowledge
//   irq_o                    level interrupt request
//   cmd_valid_o/ready_i      command handshake to the I2C engine
//   cmd_code_o[2:0]          command code
//   cmd_data_o[7:0]          DPR byte (write data or bus ID)
//   rsp_valid_i              one-cycle completion pulse from the engine
//   rsp_status_i[1:0]        00 DONE, 01 NAK, 10 ARB_LOST, 11 ERR
//   rsp_data_i[7:0]          read byte, valid with rsp_valid_i
//   bus_busy_i               selected bus busy
//   bus_captured_i           master owns the bus
// -----------------------------------------------------------------------------
module wb_cmd_responder #(
  parameter int unsigned NUM_BUSSES = 16,
  parameter int unsigned BUS_ID_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       irq_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [2:0] cmd_code_o,
  output logic [7:0] cmd_data_o,
  input  logic       rsp_valid_i,
  input  logic [1:0] rsp_status_i,
  input  logic [7:0] rsp_data_i,
  input  logic       bus_busy_i,
  input  logic       bus_captured_i
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ISSUE    = 2'b01,
    ST_WAIT_RSP = 2'b10
  } state_t;

  localparam logic [1:0] ADR_CSR  = 2'b00;
  localparam logic [1:0] ADR_DPR  = 2'b01;
  localparam logic [1:0] ADR_CMDR = 2'b10;

  localparam logic [2:0] CMD_SET_BUS   = 3'b110;
  localparam logic [2:0] CMD_READ_NACK = 3'b011;
  localparam logic [2:0] CMD_READ_ACK  = 3'b010;

  // Status nibble layout as seen in CMDR[7:4]
  localparam logic [3:0] ST_BIT_ERR = 4'b0001;

  state_t state, state_next;

  logic                ack_q;
  logic                csr_e;
  logic                csr_ie;
  logic [BUS_ID_W-1:0] bus_id;
  logic [7:0]          dpr;
  logic [3:0]          status;     // {DON, NAK, AL, ERR}
  logic [2:0]          last_cmd;
  logic                irq_q;

  // ---------------------------------------------------------------------------
  // Access decode: side effects land on the ack cycle, while the master still
  // holds address and data stable.
  // ---------------------------------------------------------------------------
  logic wr_csr, wr_dpr, wr_cmdr, rd_cmdr;
  logic is_idle, abort, cmd_launch, cmd_legal, rsp_take, status_set, ie_eff;
  logic [3:0] rsp_bits;

  assign wr_csr  = ack_q &  wb_we_i & (wb_adr_i == ADR_CSR);
  assign wr_dpr  = ack_q &  wb_we_i & (wb_adr_i == ADR_DPR);
  assign wr_cmdr = ack_q &  wb_we_i & (wb_adr_i == ADR_CMDR);
  assign rd_cmdr = ack_q & ~wb_we_i & (wb_adr_i == ADR_CMDR);

  assign is_idle    = (state == ST_IDLE);
  // Writing E=0 is a synchronous abort of whatever is in flight.
  assign abort      = wr_csr & ~wb_dat_i[7];
  assign cmd_launch = wr_cmdr & is_idle & csr_e;
  assign rsp_take   = (state == ST_WAIT_RSP) & rsp_valid_i;
  // DONE/NAK/AL/ERR map one-hot onto the status nibble, MSB first.
  assign rsp_bits   = 4'b1000 >> rsp_status_i;
  assign status_set = ~abort & ((cmd_launch & ~cmd_legal) | rsp_take);
  // IE as it will be after this cycle, so a same-cycle IE=0 write is honoured.
  assign ie_eff     = wr_csr ? wb_dat_i[6] : csr_ie;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    cmd_legal = 1'b1;
    if ((wb_dat_i[2:0] == 3'b000) || (wb_dat_i[2:0] == 3'b111)) begin
      cmd_legal = 1'b0;
    end else if ((wb_dat_i[2:0] == CMD_SET_BUS) && (32'(dpr) >= NUM_BUSSES)) begin
      cmd_legal = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or process order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (cmd_launch && cmd_legal) state_next = ST_ISSUE;
      ST_ISSUE:    if (cmd_ready_i)             state_next = ST_WAIT_RSP;
      ST_WAIT_RSP: if (rsp_valid_i)             state_next = ST_IDLE;
      default:                                  state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_comb begin
    cmd_valid_o = (state == ST_ISSUE);
  end

  // ---------------------------------------------------------------------------
  // Register file and interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q    <= 1'b0;
      csr_e    <= 1'b0;
      csr_ie   <= 1'b0;
      bus_id   <= '0;
      dpr      <= '0;
      status   <= '0;
      last_cmd <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q <= wb_cyc_i & wb_stb_i & ~ack_q;

      if (wr_csr) begin
        csr_e  <= wb_dat_i[7];
        csr_ie <= wb_dat_i[6];
      end

      if (abort) begin
        dpr    <= '0;
        status <= '0;
      end else begin
        if (wr_dpr && is_idle) dpr <= wb_dat_i;
        if (cmd_launch) begin
          last_cmd <= wb_dat_i[2:0];
          status   <= cmd_legal ? 4'b0000 : ST_BIT_ERR;
        end
        if (rsp_take) begin
          status <= rsp_bits;
          if (rsp_status_i == 2'b00) begin
            if ((last_cmd == CMD_READ_NACK) || (last_cmd == CMD_READ_ACK))
              dpr <= rsp_data_i;
            if (last_cmd == CMD_SET_BUS)
              bus_id <= dpr[BUS_ID_W-1:0];
          end
        end
      end

      // Priority: abort clears, a new status set wins over a CMDR read.
      if (abort)                     irq_q <= 1'b0;
      else if (status_set && ie_eff) irq_q <= 1'b1;
      else if (rd_cmdr || !ie_eff)   irq_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  logic [7:0] fsmr_val;
  logic [7:0] rd_mux;

`ifdef WB_CMD_RESPONDER_FSMR_EN
  assign fsmr_val = {state, cmd_valid_o, (state == ST_WAIT_RSP), last_cmd, 1'b0};
`else
  assign fsmr_val = 8'h00;
`endif

  always_comb begin
    rd_mux = 8'h00;
    unique case (wb_adr_i)
      2'b00:   rd_mux = {csr_e, csr_ie, bus_busy_i, bus_captured_i, 4'(bus_id)};
      2'b01:   rd_mux = dpr;
      2'b10:   rd_mux = {status, 1'b0, last_cmd};
      default: rd_mux = fsmr_val;
    endcase
  end

  // Data is presented only on the ack cycle so reset leaves the bus at zero.
  assign wb_dat_o   = ack_q ? rd_mux : 8'h00;
  assign wb_ack_o   = ack_q;
  assign irq_o      = irq_q;
  assign cmd_code_o = last_cmd;
  assign cmd_data_o = dpr;

endmodule

// File: tb/tb_wb_cmd_responder.sv
// -----------------------------------------------------------------------------
// Directed bench for wb_cmd_responder. Inputs change 1ns after the rising edge;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_cmd_responder;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [1:0] wb_adr_i = '0;
  logic [7:0] wb_dat_i = '0;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o, irq_o, cmd_valid_o;
  logic       cmd_ready_i = 1'b0;
  logic [2:0] cmd_code_o;
  logic [7:0] cmd_data_o;
  logic       rsp_valid_i = 1'b0;
  logic [1:0] rsp_status_i = '0;
  logic [7:0] rsp_data_i = '0;
  logic       bus_busy_i = 1'b0, bus_captured_i = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  wb_cmd_responder dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .irq_o(irq_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_code_o(cmd_code_o), .cmd_data_o(cmd_data_o),
    .rsp_valid_i(rsp_valid_i), .rsp_status_i(rsp_status_i), .rsp_data_i(rsp_data_i),
    .bus_busy_i(bus_busy_i), .bus_captured_i(bus_captured_i)
  );

  localparam logic [1:0] CSR = 2'b00, DPR = 2'b01, CMDR = 2'b10, FSMR = 2'b11;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One Wishbone transfer, bounded to 8 cycles waiting for ack.
  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] din,
                         output logic [7:0] dout);
    int n = 0;
    dout = 8'h00;
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = din;
    do begin
      @(negedge clk_i);
      n++;
    end while (!wb_ack_o && n < 8);
    check("wb_ack", 32'(wb_ack_o), 32'd1);
    dout = wb_dat_o;
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] adr, input logic [7:0] din);
    logic [7:0] unused;
    wb_xfer(1'b1, adr, din, unused);
  endtask

  task automatic rd_check(input string tag, input logic [1:0] adr, input logic [7:0] exp);
    logic [7:0] d;
    wb_xfer(1'b0, adr, 8'h00, d);
    check(tag, 32'(d), 32'(exp));
  endtask

  task automatic ready_pulse();
    @(posedge clk_i); #1; cmd_ready_i = 1'b1;
    @(posedge clk_i); #1; cmd_ready_i = 1'b0;
  endtask

  task automatic rsp_pulse(input logic [1:0] st, input logic [7:0] d);
    @(posedge clk_i); #1; rsp_valid_i = 1'b1; rsp_status_i = st; rsp_data_i = d;
    @(posedge clk_i); #1; rsp_valid_i = 1'b0;
  endtask

  initial begin
    // Reset
    #12; rst_n_i = 1'b1;
    @(negedge clk_i);
    check("rst_ack",   32'(wb_ack_o),    0);
    check("rst_irq",   32'(irq_o),       0);
    check("rst_valid", 32'(cmd_valid_o), 0);
    check("rst_cmd",   32'({cmd_code_o, cmd_data_o}), 0);
    rd_check("rst_csr", CSR, 8'h00);

    // SET_BUS 5 with ready held off 3 cycles
    wb_wr(CSR, 8'hC0);
    wb_wr(DPR, 8'h05);
    wb_wr(CMDR, 8'h06);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("setbus_hold", 32'({cmd_valid_o, cmd_code_o, cmd_data_o}), 32'({1'b1, 3'b110, 8'h05}));
    end
    ready_pulse();
    @(negedge clk_i);
    check("setbus_accepted", 32'(cmd_valid_o), 0);
    rsp_pulse(2'b00, 8'h00);
    @(negedge clk_i);
    check("setbus_irq", 32'(irq_o), 1);
    rd_check("setbus_cmdr", CMDR, 8'h86);
    check("irq_cleared_by_read", 32'(irq_o), 0);
    bus_busy_i = 1'b1; bus_captured_i = 1'b1;
    rd_check("csr_busid_bb_bc", CSR, 8'hF5);
    bus_busy_i = 1'b0; bus_captured_i = 1'b0;
    rsp_pulse(2'b11, 8'h00);            // outside WAIT_RSP: ignored
    rd_check("rsp_idle_ignored", CMDR, 8'h86);

    // SET_BUS to out-of-range bus
    wb_wr(DPR, 8'h20);
    wb_wr(CMDR, 8'h06);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("setbus_bad_novalid", 32'(cmd_valid_o), 0);
    end
    check("setbus_bad_irq", 32'(irq_o), 1);
    rd_check("setbus_bad_cmdr", CMDR, 8'h16);

    // READ_NACK with same-cycle accept
    cmd_ready_i = 1'b1;
    wb_wr(CMDR, 8'h03);
    @(negedge clk_i);
    check("rdnack_valid", 32'({cmd_valid_o, cmd_code_o}), 32'({1'b1, 3'b011}));
    @(negedge clk_i);
    check("rdnack_accepted", 32'(cmd_valid_o), 0);
    cmd_ready_i = 1'b0;
    rsp_pulse(2'b00, 8'hA5);
    rd_check("rdnack_dpr",  DPR,  8'hA5);
    rd_check("rdnack_cmdr", CMDR, 8'h83);
    rd_check("rdnack_csr",  CSR,  8'hC5);

    // WRITE answered with NAK; writes during WAIT_RSP dropped
    wb_wr(DPR, 8'h3C);
    wb_wr(CMDR, 8'h01);
    @(negedge clk_i);
    check("write_cmd", 32'({cmd_valid_o, cmd_code_o, cmd_data_o}), 32'({1'b1, 3'b001, 8'h3C}));
    ready_pulse();
    wb_wr(CMDR, 8'h04);
    wb_wr(DPR, 8'h77);
    @(negedge clk_i);
    check("busy_cmdr_dropped", 32'({cmd_valid_o, cmd_code_o, cmd_data_o}), 32'({1'b0, 3'b001, 8'h3C}));
    rsp_pulse(2'b01, 8'h00);
    rd_check("write_nak_cmdr", CMDR, 8'h41);
    rd_check("write_nak_dpr",  DPR,  8'h3C);

    // Illegal code, then clear IE to drop irq
    wb_wr(CMDR, 8'h07);
    @(negedge clk_i);
    check("illegal_irq", 32'({cmd_valid_o, irq_o}), 32'b01);
    wb_wr(CSR, 8'h80);
    @(negedge clk_i);
    check("ie_off_irq", 32'(irq_o), 0);
    rd_check("illegal_cmdr", CMDR, 8'h17);

    // Disable during ISSUE
    wb_wr(DPR, 8'h11);
    wb_wr(CMDR, 8'h05);
    @(negedge clk_i);
    check("stop_valid", 32'({cmd_valid_o, cmd_code_o, cmd_data_o}), 32'({1'b1, 3'b101, 8'h11}));
    wb_wr(CSR, 8'h00);
    @(negedge clk_i);
    check("abort_valid", 32'({cmd_valid_o, irq_o}), 0);
    rd_check("abort_csr",  CSR,  8'h05);
    rd_check("abort_dpr",  DPR,  8'h00);
    rd_check("abort_cmdr", CMDR, 8'h05);
`ifdef WB_CMD_RESPONDER_FSMR_EN
    rd_check("abort_fsmr", FSMR, 8'h0A);
`else
    rd_check("abort_fsmr", FSMR, 8'h00);
`endif
    wb_wr(CMDR, 8'h04);                 // E=0: dropped
    @(negedge clk_i);
    check("disabled_novalid", 32'(cmd_valid_o), 0);
    rd_check("disabled_cmdr", CMDR, 8'h05);

    // Reset in WAIT_RSP with irq pending
    wb_wr(CSR, 8'hC0);
    wb_wr(CMDR, 8'h07);
    wb_wr(DPR, 8'h01);
    wb_wr(CMDR, 8'h01);
    ready_pulse();
    @(negedge clk_i);
    check("pre_reset", 32'({cmd_valid_o, irq_o, cmd_code_o, cmd_data_o}),
          32'({1'b0, 1'b1, 3'b001, 8'h01}));
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    #2;
    check("reset_async", 32'({wb_ack_o, irq_o, cmd_valid_o, cmd_code_o, cmd_data_o, wb_dat_o}), 0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    rd_check("post_reset_csr",  CSR,  8'h00);
    rd_check("post_reset_cmdr", CMDR, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something wedges the directed sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_cmd_responder.md
Name: wb_cmd_responder

Overview:
- Wishbone slave front end of the I2C byte-level master.
- Decodes accesses to CSR/DPR/CMDR/FSMR and launches byte-level commands to the downstream I2C engine over a valid/ready handshake.
- Captures the engine's completion status into CMDR and raises an interrupt when enabled.
- Responder counterpart to the Wishbone command driver used by the bench.

Parameters:
- NUM_BUSSES, 16, number of selectable I2C busses; SET_BUS IDs >= NUM_BUSSES are errors.
- BUS_ID_W, 4, width of the bus ID field; NUM_BUSSES <= 2**BUS_ID_W.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  2  register select: 00 CSR, 01 DPR, 10 CMDR, 11 FSMR
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  read data
- wb_ack_o  out  1  transfer acknowledge
- irq_o  out  1  interrupt request, level
- cmd_valid_o  out  1  command offered to engine
- cmd_ready_i  in  1  engine accepts command
- cmd_code_o  out  3  command code
- cmd_data_o  out  8  DPR byte for WRITE, bus ID for SET_BUS
- rsp_valid_i  in  1  one-cycle completion pulse from engine
- rsp_status_i  in  2  00 DONE, 01 NAK, 10 ARB_LOST, 11 ERR
- rsp_data_i  in  8  read byte, valid with rsp_valid_i
- bus_busy_i  in  1  selected bus busy
- bus_captured_i  in  1  master owns the bus

Behaviour:
- Reset (async, rst_n_i low), all outputs and registers 0:
  - CSR.E=0, CSR.IE=0, bus ID 0, DPR=0, CMDR=0.
  - State IDLE; wb_ack_o, irq_o, cmd_valid_o = 0.
- Wishbone timing:
  - wb_ack_o is registered; it asserts one cycle after wb_cyc_i & wb_stb_i & !wb_ack_o and lasts exactly one cycle.
  - Register side effects are applied on the ack cycle. wb_dat_o is valid on the ack cycle.
- CSR register:
  - [7] E, RW. [6] IE, RW. [5] BB, RO = bus_busy_i. [4] BC, RO = bus_captured_i. [3:0] selected bus ID, RO.
- CMDR register:
  - [7] DON, [6] NAK, [5] AL, [4] ERR (all RO). [3] reads 0. [2:0] last command written.
- Command codes: 110 SET_BUS, 100 START, 001 WRITE, 101 STOP, 011 READ_NACK, 010 READ_ACK. Codes 000 and 111 are illegal.
- FSM states: IDLE, ISSUE, WAIT_RSP.
  - IDLE + CMDR write with E=1:
    - Clear status bits [7:4].
    - Illegal code, or SET_BUS with DPR >= NUM_BUSSES: set ERR next cycle and stay IDLE; no downstream command.
    - Otherwise go to ISSUE.
  - ISSUE: cmd_valid_o=1 with code and data held stable until cmd_ready_i; then go to WAIT_RSP. Same-cycle valid & ready counts as accepted.
  - WAIT_RSP: on rsp_valid_i, set DON/NAK/AL/ERR per rsp_status_i.
    - READ_* with status DONE: load rsp_data_i into DPR.
    - SET_BUS with status DONE: latch the bus ID.
    - Return to IDLE.
  - rsp_valid_i outside WAIT_RSP is ignored.
- Writes that are acked but dropped:
  - CMDR and DPR writes while state != IDLE.
  - CMDR writes while E=0.
- Interrupt:
  - irq_o sets on the cycle status bits get set, if IE=1.
  - irq_o clears on a CMDR read ack, or when IE is written 0.
  - Status sets coinciding with a CMDR read ack: set wins.
- Disable (CSR write with E=0):
  - Synchronous abort: state to IDLE, cmd_valid_o=0, DPR=0, status cleared, irq_o=0. IE and bus ID are retained.
- FSMR register: reads 0 unless the optional feature is enabled.

Optional Feature:
- Macro WB_CMD_RESPONDER_FSMR_EN.
- Defined: FSMR reads {state[1:0], cmd_valid_o, rsp pending, last cmd[2:0], 1'b0}, where rsp pending = state==WAIT_RSP.
- Undefined: FSMR reads 8'h00; no extra logic.

Test Plan:
- Reset mid-transaction (state WAIT_RSP, rst_n_i low) -> all outputs 0 immediately; CSR reads 8'h00 after release.
- Write CSR 8'hC0, DPR 8'h05, CMDR 8'h06 -> cmd_valid_o with code 110 and data 8'h05; hold cmd_ready_i low 3 cycles -> outputs stable. After rsp DONE: CMDR reads 8'h86, CSR[3:0]=5, irq_o=1. CMDR read -> irq_o=0.
- DPR 8'h20 (>= 16), CMDR SET_BUS -> CMDR reads 8'h16 (ERR), cmd_valid_o never asserts.
- READ_NACK (CMDR 8'h03), rsp DONE with data 8'hA5 -> DPR reads 8'hA5, CMDR reads 8'h83.
- WRITE with rsp NAK -> CMDR reads 8'h41. Second CMDR write during WAIT_RSP -> acked, dropped; cmd_code_o unchanged.
- Illegal code 8'h07 -> ERR set. CSR write 8'h00 during ISSUE -> cmd_valid_o drops next cycle, state IDLE, IE retained as 0.
